// File: rtl/scroller_pkg.sv
// Shared constants and small helpers for the scrolling message display.
package scroller_pkg;

  localparam int MSG_LEN = 16;
  localparam int POS_W   = 4;
  localparam int CHAR_W  = 4;

  typedef logic [POS_W-1:0]  pos_t;
  typedef logic [CHAR_W-1:0] char_t;

  // Slot i powers up holding character code i.
  localparam logic [MSG_LEN*CHAR_W-1:0] RESET_MSG = 64'hFEDC_BA98_7654_3210;

  // Index into the message relative to the window start, wrapping mod 16.
  function automatic pos_t win_idx(input pos_t base, input int unsigned off);
    return base + pos_t'(off);
  endfunction

  function automatic pos_t pos_step(input pos_t p, input logic d);
    return d ? p - pos_t'(1) : p + pos_t'(1);
  endfunction

endpackage

// File: rtl/tick_divider.sv
// Free-running step timer: counts 0..PERIOD-1 and flags the terminal count.
module tick_divider #(
  parameter int PERIOD = 25000000
) (
  input  logic clk,
  input  logic reset,
  input  logic hold,
  input  logic clear,
  output logic tick
);

  localparam int CNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;

  logic [CNT_W-1:0] count;

  assign tick = !hold && (count == CNT_W'(PERIOD - 1));

  // clear outranks hold so a manual step restarts the period even while paused
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (!hold) begin
      count <= tick ? '0 : count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/msg_scroller.sv
// Scrolls a 4-character window across a 16-character message store.
// Optional manual step button enabled by defining STEP_BTN_EN.
module msg_scroller #(
  parameter int SCROLL_PERIOD = 25000000,
  parameter int MSG_LEN       = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           pause,
  input  logic                           dir,
  input  logic                           load_en,
  input  logic [scroller_pkg::POS_W-1:0] load_addr,
  input  logic [scroller_pkg::CHAR_W-1:0] load_data,
  input  logic                           step,
  output logic [scroller_pkg::CHAR_W-1:0] char3,
  output logic [scroller_pkg::CHAR_W-1:0] char2,
  output logic [scroller_pkg::CHAR_W-1:0] char1,
  output logic [scroller_pkg::CHAR_W-1:0] char0,
  output logic [scroller_pkg::POS_W-1:0]  pos,
  output logic                           wrap
);

  import scroller_pkg::*;

  logic  tick;
  logic  adv;
  logic  clr;
  char_t msg [MSG_LEN];

`ifdef STEP_BTN_EN
  logic step_p0, step_p1, step_p2;
  logic btn_edge;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      step_p0 <= 1'b0;
      step_p1 <= 1'b0;
      step_p2 <= 1'b0;
    end else begin
      step_p0 <= step;
      step_p1 <= step_p0;
      step_p2 <= step_p1;
    end
  end

  // Button edge and timer terminal count merge into a single advance.
  assign btn_edge = step_p1 & ~step_p2;
  assign adv      = tick | btn_edge;
  assign clr      = btn_edge;
`else
  logic unused_step;
  assign unused_step = step;
  assign adv         = tick;
  assign clr         = 1'b0;
`endif

  tick_divider #(
    .PERIOD(SCROLL_PERIOD)
  ) u_timer (
    .clk  (clk),
    .reset(reset),
    .hold (pause),
    .clear(clr),
    .tick (tick)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pos  <= '0;
      wrap <= 1'b0;
    end else begin
      wrap <= adv && (dir ? (pos == '0) : (pos == '1));
      if (adv) begin
        pos <= pos_step(pos, dir);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < MSG_LEN; i++) begin
        msg[i] <= RESET_MSG[i*CHAR_W +: CHAR_W];
      end
    end else if (load_en) begin
      msg[load_addr] <= load_data;
    end
  end

  // Window is sampled from pre-edge pos/msg, so chars trail pos by one cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      char3 <= RESET_MSG[0*CHAR_W +: CHAR_W];
      char2 <= RESET_MSG[1*CHAR_W +: CHAR_W];
      char1 <= RESET_MSG[2*CHAR_W +: CHAR_W];
      char0 <= RESET_MSG[3*CHAR_W +: CHAR_W];
    end else begin
      char3 <= msg[pos];
      char2 <= msg[win_idx(pos, 1)];
      char1 <= msg[win_idx(pos, 2)];
      char0 <= msg[win_idx(pos, 3)];
    end
  end

endmodule

// File: tb/tb_msg_scroller.sv
// Directed-vector bench for msg_scroller with SCROLL_PERIOD=4.
module tb_msg_scroller;

  localparam int P = 4;

  logic       clk = 1'b0;
  logic       reset, pause, dir, load_en, step;
  logic [3:0] load_addr, load_data;
  logic [3:0] char3, char2, char1, char0, pos;
  logic       wrap;
  logic [15:0] chars;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign chars = {char3, char2, char1, char0};

  msg_scroller #(
    .SCROLL_PERIOD(P),
    .MSG_LEN      (16)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .pause    (pause),
    .dir      (dir),
    .load_en  (load_en),
    .load_addr(load_addr),
    .load_data(load_data),
    .step     (step),
    .char3    (char3),
    .char2    (char2),
    .char1    (char1),
    .char0    (char0),
    .pos      (pos),
    .wrap     (wrap)
  );

  typedef struct {
    logic        pause;
    logic        dir;
    logic        ld;
    logic [3:0]  la;
    logic [3:0]  ldat;
    logic [3:0]  exp_pos;
    logic        exp_wrap;
    logic [15:0] exp_chars;
  } vec_t;

  vec_t vt[19];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b0; pause = 1'b0; dir = 1'b0; load_en = 1'b0; step = 1'b0;
    load_addr = 4'h0; load_data = 4'h0;
    cyc(2);
    chk({tag, "_rst_pos"}, {12'h0, pos}, 16'h0000);
    chk({tag, "_rst_wrap"}, {15'h0, wrap}, 16'h0000);
    chk({tag, "_rst_chars"}, chars, 16'h0123);
    reset = 1'b1;
  endtask

  initial begin
    vt[0]  = '{1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 4'd0, 1'b0, 16'h0123};
    vt[1]  = '{1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 4'd0, 1'b0, 16'h0123};
    vt[2]  = '{1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 4'd0, 1'b0, 16'h0123};
    vt[3]  = '{1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 4'd1, 1'b0, 16'h0123};
    vt[4]  = '{1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 4'd1, 1'b0, 16'h1234};
    vt[5]  = '{1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 4'd1, 1'b0, 16'h1234};
    vt[6]  = '{1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 4'd1, 1'b0, 16'h1234};
    vt[7]  = '{1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 4'd2, 1'b0, 16'h1234};
    vt[8]  = '{1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 4'd2, 1'b0, 16'h2345};
    vt[9]  = '{1'b0, 1'b0, 1'b1, 4'h4, 4'hA, 4'd2, 1'b0, 16'h2345};
    vt[10] = '{1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 4'd2, 1'b0, 16'h23A5};
    vt[11] = '{1'b0, 1'b0, 1'b1, 4'h7, 4'hC, 4'd3, 1'b0, 16'h23A5};
    vt[12] = '{1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 4'd3, 1'b0, 16'h3A56};
    vt[13] = '{1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 4'd3, 1'b0, 16'h3A56};
    vt[14] = '{1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 4'd3, 1'b0, 16'h3A56};
    vt[15] = '{1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 4'd3, 1'b0, 16'h3A56};
    vt[16] = '{1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 4'd3, 1'b0, 16'h3A56};
    vt[17] = '{1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 4'd2, 1'b0, 16'h3A56};
    vt[18] = '{1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 4'd2, 1'b0, 16'h23A5};

    reset = 1'b0;
    @(negedge clk);

    // Table: basic scrolling, loads, pause, direction change
    do_reset("tbl");
    for (int i = 0; i < 19; i++) begin
      pause = vt[i].pause; dir = vt[i].dir; load_en = vt[i].ld;
      load_addr = vt[i].la; load_data = vt[i].ldat;
      cyc(1);
      chk($sformatf("row%0d_pos", i), {12'h0, pos}, {12'h0, vt[i].exp_pos});
      chk($sformatf("row%0d_wrap", i), {15'h0, wrap}, {15'h0, vt[i].exp_wrap});
      chk($sformatf("row%0d_chars", i), chars, vt[i].exp_chars);
    end
    load_en = 1'b0; pause = 1'b0; dir = 1'b0;

    // Forward wrap 15->0, then backward wrap 0->15
    do_reset("wrap");
    cyc(60);
    chk("fwd_pos15", {12'h0, pos}, 16'h000F);
    cyc(3);
    chk("fwd_prewrap", {15'h0, wrap}, 16'h0000);
    cyc(1);
    chk("fwd_pos0", {12'h0, pos}, 16'h0000);
    chk("fwd_wrap_hi", {15'h0, wrap}, 16'h0001);
    dir = 1'b1;
    cyc(1);
    chk("fwd_wrap_lo", {15'h0, wrap}, 16'h0000);
    chk("fwd_chars", chars, 16'h0123);
    cyc(2);
    chk("bwd_pos0", {12'h0, pos}, 16'h0000);
    chk("bwd_prewrap", {15'h0, wrap}, 16'h0000);
    cyc(1);
    chk("bwd_pos15", {12'h0, pos}, 16'h000F);
    chk("bwd_wrap_hi", {15'h0, wrap}, 16'h0001);
    cyc(1);
    chk("bwd_wrap_lo", {15'h0, wrap}, 16'h0000);
    chk("bwd_chars", chars, 16'hF012);
    dir = 1'b0;

    // Pause at timer=2 for 10 cycles, step 2 cycles after release
    do_reset("pause");
    cyc(2);
    pause = 1'b1;
    cyc(10);
    chk("pause_hold", {12'h0, pos}, 16'h0000);
    pause = 1'b0;
    cyc(1);
    chk("pause_rel1", {12'h0, pos}, 16'h0000);
    cyc(1);
    chk("pause_rel2", {12'h0, pos}, 16'h0001);

    // Write inside window at pos 0 without a scroll
    do_reset("ld");
    cyc(1);
    load_en = 1'b1; load_addr = 4'h2; load_data = 4'hA;
    cyc(1);
    load_en = 1'b0;
    chk("ld_same", chars, 16'h0123);
    cyc(1);
    chk("ld_char1", chars, 16'h01A3);

    // Write coinciding with a scroll step
    do_reset("ldsc");
    cyc(3);
    load_en = 1'b1; load_addr = 4'h2; load_data = 4'hA;
    cyc(1);
    load_en = 1'b0;
    chk("ldsc_pos", {12'h0, pos}, 16'h0001);
    chk("ldsc_old", chars, 16'h0123);
    cyc(1);
    chk("ldsc_new", chars, 16'h1A34);

    // Asynchronous reset mid-period
    do_reset("ar");
    cyc(4);
    load_en = 1'b1; load_addr = 4'h2; load_data = 4'hD;
    cyc(1);
    load_en = 1'b0;
    cyc(1);
    chk("ar_pre_chars", chars, 16'h1D34);
    cyc(1);
    reset = 1'b0;
    #1;
    chk("ar_pos", {12'h0, pos}, 16'h0000);
    chk("ar_wrap", {15'h0, wrap}, 16'h0000);
    chk("ar_chars", chars, 16'h0123);
    cyc(2);
    reset = 1'b1;
    cyc(3);
    chk("ar_rel3", {12'h0, pos}, 16'h0000);
    chk("ar_msg", chars, 16'h0123);
    cyc(1);
    chk("ar_rel4", {12'h0, pos}, 16'h0001);

`ifdef STEP_BTN_EN
    // Manual step while paused, then step edge on terminal count
    do_reset("btn");
    pause = 1'b1; step = 1'b1;
    cyc(2);
    chk("btn_lat2", {12'h0, pos}, 16'h0000);
    cyc(1);
    chk("btn_lat3", {12'h0, pos}, 16'h0001);
    step = 1'b0; pause = 1'b0;
    cyc(3);
    chk("btn_tclr3", {12'h0, pos}, 16'h0001);
    cyc(1);
    chk("btn_tclr4", {12'h0, pos}, 16'h0002);
    cyc(1);
    step = 1'b1;
    cyc(3);
    chk("btn_coinc", {12'h0, pos}, 16'h0003);
    step = 1'b0;
    cyc(3);
    chk("btn_after3", {12'h0, pos}, 16'h0003);
    cyc(1);
    chk("btn_after4", {12'h0, pos}, 16'h0004);
`else
    // Step input has no effect in the default build
    do_reset("nobtn");
    pause = 1'b1; step = 1'b1;
    cyc(5);
    chk("nobtn_pos", {12'h0, pos}, 16'h0000);
    step = 1'b0; pause = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
